// File: rtl/hex_str_pkg.sv
// rtl/hex_str_pkg.sv - shared state encoding and ASCII constants for the hex-string link
package hex_str_pkg;

  // Encoding is shared with the receiving checker FSM; keep values fixed.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    STOP     = 3'd2,
    HEXDIGIT = 3'd4
  } hex_state_e;

  localparam logic [7:0] ASCII_NUL = 8'h00;
  localparam logic [7:0] ASCII_0   = 8'h30;
  localparam logic [7:0] ASCII_UA  = 8'h41;
  localparam logic [7:0] ASCII_LA  = 8'h61;

endpackage

// File: rtl/nibble_to_ascii.sv
// rtl/nibble_to_ascii.sv - 4-bit nibble to ASCII hex character (LOWERCASE_HEX_EN selects a-f)
module nibble_to_ascii
  import hex_str_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [7:0] ascii_o
);

`ifdef LOWERCASE_HEX_EN
  localparam logic [7:0] ALPHA_BASE = ASCII_LA;
`else
  localparam logic [7:0] ALPHA_BASE = ASCII_UA;
`endif

  always_comb begin
    if (nib_i < 4'd10) begin
      ascii_o = ASCII_0 + {4'h0, nib_i};
    end else begin
      ascii_o = ALPHA_BASE + {4'h0, nib_i} - 8'd10;
    end
  end

endmodule

// File: rtl/hex_string_tx.sv
// rtl/hex_string_tx.sv - serializes a DIGITS-nibble word as 0x00, hex chars (MSB first), 0x00
// Optional: LOWERCASE_HEX_EN (lowercase a-f characters).
module hex_string_tx
  import hex_str_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_valid,
  input  logic [4*DIGITS-1:0]   load_data,
  output logic                  load_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  tx_last,
  output logic                  busy
);

  localparam int DATA_W = 4 * DIGITS;
  localparam logic [3:0] K_LAST = 4'(DIGITS - 1);

  if (DIGITS < 1 || DIGITS > 15) begin : g_bad_digits
    $error("hex_string_tx: DIGITS must be within 1..15");
  end

  hex_state_e        state_q, state_d;
  logic [3:0]        k_q, k_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              tx_last_q, tx_last_d;

  logic [DATA_W-1:0] word_shift;
  logic [3:0]        nib;
  logic [7:0]        nib_ascii;
  logic              xfer;

  assign xfer       = tx_valid_q && tx_ready;
  assign word_shift = word_q << 4;
  // START emits the top nibble as-is; HEXDIGIT emits the nibble that becomes top after the shift.
  assign nib        = (state_q == START) ? word_q[DATA_W-1 -: 4] : word_shift[DATA_W-1 -: 4];

  nibble_to_ascii u_nib (
    .nib_i   (nib),
    .ascii_o (nib_ascii)
  );

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    word_d     = word_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_last_d  = tx_last_q;
    case (state_q)
      IDLE: begin
        if (load_valid) begin
          state_d    = START;
          word_d     = load_data;
          tx_valid_d = 1'b1;
          tx_data_d  = ASCII_NUL;
          tx_last_d  = 1'b0;
        end
      end
      START: begin
        if (xfer) begin
          state_d   = HEXDIGIT;
          k_d       = 4'd0;
          tx_data_d = nib_ascii;
        end
      end
      HEXDIGIT: begin
        if (xfer) begin
          if (k_q == K_LAST) begin
            state_d   = STOP;
            tx_data_d = ASCII_NUL;
            tx_last_d = 1'b1;
          end else begin
            k_d       = k_q + 4'd1;
            word_d    = word_shift;
            tx_data_d = nib_ascii;
          end
        end
      end
      STOP: begin
        if (xfer) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
          tx_last_d  = 1'b0;
        end
      end
      default: begin
        state_d    = IDLE;
        tx_valid_d = 1'b0;
        tx_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= 4'd0;
      word_q     <= '0;
      tx_data_q  <= ASCII_NUL;
      tx_valid_q <= 1'b0;
      tx_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      word_q     <= word_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_last_q  <= tx_last_d;
    end
  end

  assign load_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign tx_last    = tx_last_q;

endmodule

// File: tb/tb_hex_string_tx.sv
// tb/tb_hex_string_tx.sv - directed self-checking bench for hex_string_tx (DIGITS=8 and DIGITS=2)
module tb_hex_string_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid, tx_ready;
  logic [31:0] load_data;
  logic        load_ready, tx_valid, tx_last, busy;
  logic [7:0]  tx_data;

  logic        load_valid2, tx_ready2;
  logic [7:0]  load_data2;
  logic        load_ready2, tx_valid2, tx_last2, busy2;
  logic [7:0]  tx_data2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hex_string_tx #(.DIGITS(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_last(tx_last), .busy(busy)
  );

  hex_string_tx #(.DIGITS(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(load_valid2), .load_data(load_data2),
    .load_ready(load_ready2), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .tx_last(tx_last2), .busy(busy2)
  );

`ifdef LOWERCASE_HEX_EN
  localparam logic [79:0] EXP_DEADBEEF = 80'h00_64_65_61_64_62_65_65_66_00;
  localparam logic [79:0] EXP_0123ABCD = 80'h00_30_31_32_33_61_62_63_64_00;
  localparam logic [31:0] EXP_0A       = 32'h00_30_61_00;
`else
  localparam logic [79:0] EXP_DEADBEEF = 80'h00_44_45_41_44_42_45_45_46_00;
  localparam logic [79:0] EXP_0123ABCD = 80'h00_30_31_32_33_41_42_43_44_00;
  localparam logic [31:0] EXP_0A       = 32'h00_30_41_00;
`endif
  localparam logic [79:0] EXP_12345678 = 80'h00_31_32_33_34_35_36_37_38_00;
  localparam logic [79:0] EXP_ZERO     = 80'h00_30_30_30_30_30_30_30_30_00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Load w, then walk the 10-byte frame with tx_ready high except for an
  // optional 3-cycle stall on byte stall_at; hold_load keeps load_valid up
  // (with a bogus word) for the whole frame.
  task automatic run_frame(input string tag, input logic [31:0] w, input logic [79:0] e,
                           input int stall_at, input bit hold_load);
    chk({tag, "_load_ready_pre"}, {31'd0, load_ready}, 32'd1);
    load_valid = 1'b1;
    load_data  = w;
    @(negedge clk);
    if (hold_load) load_data = 32'hFFFF_FFFF;
    else           load_valid = 1'b0;
    chk({tag, "_load_ready_busy"}, {31'd0, load_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), {31'd0, tx_valid}, 32'd1);
      chk($sformatf("%s_data%0d", tag, i), {24'd0, tx_data}, {24'd0, e[79-8*i -: 8]});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, tx_last}, {31'd0, (i == 9)});
      if (i == stall_at) begin
        tx_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          chk($sformatf("%s_stall_data%0d", tag, s), {24'd0, tx_data}, {24'd0, e[79-8*i -: 8]});
          chk($sformatf("%s_stall_valid%0d", tag, s), {31'd0, tx_valid}, 32'd1);
        end
        tx_ready = 1'b1;
      end
      if (i == 9) load_valid = 1'b0;
      @(negedge clk);
    end
    chk({tag, "_load_ready_post"}, {31'd0, load_ready}, 32'd1);
    chk({tag, "_busy_post"}, {31'd0, busy}, 32'd0);
    chk({tag, "_valid_post"}, {31'd0, tx_valid}, 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    load_valid  = 1'b0;
    load_data   = 32'd0;
    tx_ready    = 1'b1;
    load_valid2 = 1'b0;
    load_data2  = 8'd0;
    tx_ready2   = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_data", {24'd0, tx_data}, 32'd0);
    chk("rst_last", {31'd0, tx_last}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_frame("t1_deadbeef", 32'hDEAD_BEEF, EXP_DEADBEEF, -1, 1'b0);
    run_frame("t3_stall", 32'h0123_ABCD, EXP_0123ABCD, 2, 1'b0);
    run_frame("t4_ignore", 32'h1234_5678, EXP_12345678, -1, 1'b1);

    // Abort mid-frame: four bytes transferred, fifth on the wire.
    load_valid = 1'b1;
    load_data  = 32'h1234_5678;
    @(negedge clk);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_pre_data", {24'd0, tx_data}, 32'h34);
    rst_n = 1'b0;
    #1;
    chk("t5_abort_valid", {31'd0, tx_valid}, 32'd0);
    chk("t5_abort_busy", {31'd0, busy}, 32'd0);
    chk("t5_abort_ready", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame("t5_zero", 32'h0000_0000, EXP_ZERO, -1, 1'b0);

    // DIGITS=2 instance.
    load_valid2 = 1'b1;
    load_data2  = 8'h0A;
    @(negedge clk);
    load_valid2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t6_valid%0d", i), {31'd0, tx_valid2}, 32'd1);
      chk($sformatf("t6_data%0d", i), {24'd0, tx_data2}, {24'd0, EXP_0A[31-8*i -: 8]});
      chk($sformatf("t6_last%0d", i), {31'd0, tx_last2}, {31'd0, (i == 3)});
      @(negedge clk);
    end
    chk("t6_ready_post", {31'd0, load_ready2}, 32'd1);
    chk("t6_valid_post", {31'd0, tx_valid2}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
